// File: rtl/lcd_seq_pkg.sv
// rtl/lcd_seq_pkg.sv - shared codes, opcodes and state encoding for lcd_seq8080
// Contents: port8080 function codes, display opcodes, FSM state constants,
//           argument-byte selector and window pixel-count helper.
package lcd_seq_pkg;

  // port8080 function codes
  localparam logic [2:0] FUNC_CMD = 3'd1;
  localparam logic [2:0] FUNC_RD  = 3'd2;
  localparam logic [2:0] FUNC_DAT = 3'd3;

  // display controller opcodes
  localparam logic [7:0] CASET = 8'h2A;
  localparam logic [7:0] PASET = 8'h2B;
  localparam logic [7:0] RAMWR = 8'h2C;

  // sequencer states
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CHK    = 3'd1;
  localparam logic [2:0] ST_CMD    = 3'd2;
  localparam logic [2:0] ST_ARG    = 3'd3;
  localparam logic [2:0] ST_PIX_HI = 3'd4;
  localparam logic [2:0] ST_PIX_LO = 3'd5;
  localparam logic [2:0] ST_WAIT   = 3'd6;
  localparam logic [2:0] ST_DONE   = 3'd7;

  // Argument bytes of one address command: start hi, start lo, end hi, end lo.
  function automatic logic [7:0] arg_byte(input logic [15:0] first,
                                          input logic [15:0] last,
                                          input logic [1:0]  idx);
    case (idx)
      2'd0:    arg_byte = first[15:8];
      2'd1:    arg_byte = first[7:0];
      2'd2:    arg_byte = last[15:8];
      default: arg_byte = last[7:0];
    endcase
  endfunction

  // Inclusive window area, truncated to 32 bits (a full 65536x65536 window
  // wraps to 0, which the down-counter then treats as 2^32 pixels).
  function automatic logic [31:0] pixel_count(input logic [15:0] xa,
                                              input logic [15:0] xb,
                                              input logic [15:0] ya,
                                              input logic [15:0] yb);
    logic [16:0] w;
    logic [16:0] h;
    logic [33:0] p;
    w = {1'b0, xb} - {1'b0, xa} + 17'd1;
    h = {1'b0, yb} - {1'b0, ya} + 17'd1;
    p = {17'd0, w} * {17'd0, h};
    pixel_count = p[31:0];
  endfunction

endpackage

// File: rtl/lcd_seq8080.sv
// rtl/lcd_seq8080.sv - 8080-bus window fill sequencer (CASET/PASET/RAMWR + pixels)
// Ports: CLK/RST (sync active-high); start, x0/x1/y0/y1 window request;
//        pix_data/pix_valid/pix_ready pixel stream; p_cmd/p_data/p_func/p_en
//        issue to port8080, p_busy back; busy/done/err status.
// Build option: LCD_SEQ8080_BYTESWAP_EN issues each pixel lo byte first.
module lcd_seq8080
  import lcd_seq_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  input  logic [15:0] x0,
  input  logic [15:0] x1,
  input  logic [15:0] y0,
  input  logic [15:0] y1,
  input  logic [15:0] pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic [7:0]  p_cmd,
  output logic [7:0]  p_data,
  output logic [2:0]  p_func,
  output logic        p_en,
  input  logic        p_busy,
  output logic        busy,
  output logic        done,
  output logic        err
);

  logic [2:0]  state;
  logic [2:0]  ret_state;   // where WAIT goes next; ST_DONE marks end of a pixel
  logic        guard;       // first WAIT cycle, p_busy not yet meaningful
  logic [1:0]  phase;       // 0 CASET, 1 PASET, 2 RAMWR
  logic [2:0]  arg_idx;     // 0..3 x bytes, 4..7 y bytes
  logic [31:0] count;
  logic [15:0] wx0, wx1, wy0, wy1;
  logic [7:0]  pix_second;

  logic        window_bad;
  logic [7:0]  opcode;
  logic [7:0]  arg_value;
  logic [7:0]  pix_first_b;
  logic [7:0]  pix_second_b;

  always_comb begin
    window_bad = (wx1 < wx0) || (wy1 < wy0);
    case (phase)
      2'd0:    opcode = CASET;
      2'd1:    opcode = PASET;
      default: opcode = RAMWR;
    endcase
    arg_value = arg_idx[2] ? arg_byte(wy0, wy1, arg_idx[1:0])
                           : arg_byte(wx0, wx1, arg_idx[1:0]);
`ifdef LCD_SEQ8080_BYTESWAP_EN
    pix_first_b  = pix_data[7:0];
    pix_second_b = pix_data[15:8];
`else
    pix_first_b  = pix_data[15:8];
    pix_second_b = pix_data[7:0];
`endif
  end

  assign busy      = (state != ST_IDLE);
  assign pix_ready = (state == ST_PIX_HI);
  assign done      = (state == ST_DONE);
  assign err       = (state == ST_CHK) && window_bad;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= ST_IDLE;
      ret_state  <= ST_IDLE;
      guard      <= 1'b0;
      phase      <= 2'd0;
      arg_idx    <= 3'd0;
      count      <= 32'd0;
      wx0        <= 16'd0;
      wx1        <= 16'd0;
      wy0        <= 16'd0;
      wy1        <= 16'd0;
      pix_second <= 8'd0;
      p_cmd      <= 8'd0;
      p_data     <= 8'd0;
      p_func     <= 3'd0;
      p_en       <= 1'b0;
    end else begin
      p_en <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            wx0   <= x0;
            wx1   <= x1;
            wy0   <= y0;
            wy1   <= y1;
            state <= ST_CHK;
          end
        end
        ST_CHK: begin
          if (window_bad) begin
            state <= ST_IDLE;
          end else begin
            count   <= pixel_count(wx0, wx1, wy0, wy1);
            phase   <= 2'd0;
            arg_idx <= 3'd0;
            state   <= ST_CMD;
          end
        end
        ST_CMD: begin
          p_en      <= 1'b1;
          p_func    <= FUNC_CMD;
          p_cmd     <= opcode;
          guard     <= 1'b1;
          ret_state <= (phase == 2'd2) ? ST_PIX_HI : ST_ARG;
          state     <= ST_WAIT;
        end
        ST_ARG: begin
          p_en    <= 1'b1;
          p_func  <= FUNC_DAT;
          p_data  <= arg_value;
          guard   <= 1'b1;
          arg_idx <= arg_idx + 3'd1;
          if (arg_idx[1:0] == 2'd3) begin
            phase     <= phase + 2'd1;
            ret_state <= ST_CMD;
          end else begin
            ret_state <= ST_ARG;
          end
          state <= ST_WAIT;
        end
        ST_PIX_HI: begin
          if (pix_valid) begin
            p_en       <= 1'b1;
            p_func     <= FUNC_DAT;
            p_data     <= pix_first_b;
            pix_second <= pix_second_b;
            guard      <= 1'b1;
            ret_state  <= ST_PIX_LO;
            state      <= ST_WAIT;
          end
        end
        ST_PIX_LO: begin
          p_en      <= 1'b1;
          p_func    <= FUNC_DAT;
          p_data    <= pix_second;
          guard     <= 1'b1;
          ret_state <= ST_DONE;
          state     <= ST_WAIT;
        end
        ST_WAIT: begin
          if (guard) begin
            guard <= 1'b0;
          end else if (!p_busy) begin
            if (ret_state == ST_DONE) begin
              count <= count - 32'd1;
              state <= (count == 32'd1) ? ST_DONE : ST_PIX_HI;
            end else begin
              state <= ret_state;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_seq8080.sv
// tb/tb_lcd_seq8080.sv - self-checking bench for lcd_seq8080 with a 3-cycle-busy port model
module tb_lcd_seq8080;
  import lcd_seq_pkg::*;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        start = 1'b0;
  logic [15:0] x0 = 16'd0, x1 = 16'd0, y0 = 16'd0, y1 = 16'd0;
  logic [15:0] pix_data = 16'd0;
  logic        pix_valid = 1'b0;
  logic        pix_ready;
  logic [7:0]  p_cmd, p_data;
  logic [2:0]  p_func;
  logic        p_en;
  logic        p_busy;
  logic        busy, done, err;

  lcd_seq8080 dut (
    .CLK(CLK), .RST(RST), .start(start),
    .x0(x0), .x1(x1), .y0(y0), .y1(y1),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .p_cmd(p_cmd), .p_data(p_data), .p_func(p_func), .p_en(p_en),
    .p_busy(p_busy), .busy(busy), .done(done), .err(err)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running, want finished");
    $fatal(1);
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  // Port model: busy for 3 cycles after each strobe.
  int busy_cnt;
  always @(posedge CLK) begin
    if (RST) busy_cnt <= 0;
    else if (p_en) busy_cnt <= 3;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign p_busy = (busy_cnt != 0);

  // Expected issue stream, {func, byte}, built from the window rules.
  logic [10:0] exp_q[$];
  logic [15:0] pix_list[16];

  task automatic push(input logic [2:0] f, input logic [7:0] b);
    exp_q.push_back({f, b});
  endtask

  task automatic build_expected(input logic [15:0] xa, input logic [15:0] xb,
                                input logic [15:0] ya, input logic [15:0] yb,
                                input int npix);
    exp_q.delete();
    push(FUNC_CMD, 8'h2A);
    push(FUNC_DAT, xa[15:8]); push(FUNC_DAT, xa[7:0]);
    push(FUNC_DAT, xb[15:8]); push(FUNC_DAT, xb[7:0]);
    push(FUNC_CMD, 8'h2B);
    push(FUNC_DAT, ya[15:8]); push(FUNC_DAT, ya[7:0]);
    push(FUNC_DAT, yb[15:8]); push(FUNC_DAT, yb[7:0]);
    push(FUNC_CMD, 8'h2C);
    for (int i = 0; i < npix; i++) begin
`ifdef LCD_SEQ8080_BYTESWAP_EN
      push(FUNC_DAT, pix_list[i][7:0]);
      push(FUNC_DAT, pix_list[i][15:8]);
`else
      push(FUNC_DAT, pix_list[i][15:8]);
      push(FUNC_DAT, pix_list[i][7:0]);
`endif
    end
  endtask

  // Compare process: every strobe against the model, held values between strobes.
  logic        monitor_on = 1'b0;
  int          strobes = 0, dones = 0, errs = 0;
  logic [7:0]  last_cmd, last_data;
  logic [2:0]  last_func;
  logic [10:0] mon_e;

  always @(negedge CLK) begin
    if (RST) begin
      last_cmd = 8'd0; last_data = 8'd0; last_func = 3'd0;
    end else if (monitor_on) begin
      if (p_en) begin
        strobes++;
        if (exp_q.size() == 0) begin
          check("extra_strobe", strobes, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("strobe_func", p_func, mon_e[10:8]);
          if (mon_e[10:8] == FUNC_CMD) begin
            check("strobe_cmd", p_cmd, mon_e[7:0]);
            check("strobe_data_held", p_data, last_data);
            last_cmd = mon_e[7:0];
          end else begin
            check("strobe_data", p_data, mon_e[7:0]);
            check("strobe_cmd_held", p_cmd, last_cmd);
            last_data = mon_e[7:0];
          end
          last_func = mon_e[10:8];
        end
      end else begin
        check("hold_func", p_func, last_func);
        check("hold_cmd", p_cmd, last_cmd);
        check("hold_data", p_data, last_data);
      end
      if (done) begin
        dones++;
        check("done_queue_empty", exp_q.size(), 0);
      end
      if (err) errs++;
    end
  end

  task automatic pulse_start(input logic [15:0] xa, input logic [15:0] xb,
                             input logic [15:0] ya, input logic [15:0] yb);
    @(negedge CLK);
    x0 = xa; x1 = xb; y0 = ya; y1 = yb;
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
  endtask

  task automatic feed_pixels(input int npix, input int stall_idx, input int stall_len);
    int t;
    for (int i = 0; i < npix; i++) begin
      t = 0;
      @(negedge CLK);
      while (!pix_ready && t < 1000) begin
        @(negedge CLK);
        t++;
      end
      if (!pix_ready) begin
        check("ready_timeout", t, 0);
        return;
      end
      if (i == stall_idx) begin
        for (int k = 0; k < stall_len; k++) begin
          check("stall_no_pen", p_en, 0);
          check("stall_ready_held", pix_ready, 1);
          @(negedge CLK);
        end
      end
      pix_data  = pix_list[i];
      pix_valid = 1'b1;
      @(posedge CLK);
      #1 pix_valid = 1'b0;
    end
  endtask

  task automatic wait_done(input int d0);
    int t;
    t = 0;
    while (dones == d0 && t < 3000) begin
      @(posedge CLK);
      t++;
    end
    if (dones == d0) check("done_timeout", t, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_p_en"}, p_en, 0);
    check({tag, "_pix_ready"}, pix_ready, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_p_cmd"}, p_cmd, 0);
    check({tag, "_p_data"}, p_data, 0);
    check({tag, "_p_func"}, p_func, 0);
  endtask

  task automatic run_fill(input string tag, input logic [15:0] xa, input logic [15:0] xb,
                          input logic [15:0] ya, input logic [15:0] yb,
                          input int npix, input int stall_idx, input int stall_len,
                          input int want_strobes);
    int s0, d0;
    build_expected(xa, xb, ya, yb, npix);
    s0 = strobes; d0 = dones;
    pulse_start(xa, xb, ya, yb);
    feed_pixels(npix, stall_idx, stall_len);
    wait_done(d0);
    @(negedge CLK);
    check({tag, "_strobes"}, strobes - s0, want_strobes);
    check({tag, "_queue_empty"}, exp_q.size(), 0);
    check({tag, "_done_count"}, dones - d0, 1);
    check({tag, "_busy_after"}, busy, 0);
  endtask

  logic [7:0] lit_bytes[15] = '{8'h2A, 8'h00, 8'h00, 8'h00, 8'h01,
                                8'h2B, 8'h00, 8'h00, 8'h00, 8'h00,
                                8'h2C, 8'hF8, 8'h00, 8'h07, 8'hE0};

  initial begin
    int s0, d0, e0, t;
    logic [7:0] want_first;

    repeat (3) @(posedge CLK);
    #1 check_reset_outputs("reset");
    @(negedge CLK);
    RST = 1'b0;
    monitor_on = 1'b1;

    // Pin the model against the hand-written 1x2 stream.
    pix_list[0] = 16'hF800; pix_list[1] = 16'h07E0;
    build_expected(16'd0, 16'd1, 16'd0, 16'd0, 2);
    check("pin_len", exp_q.size(), 15);
`ifndef LCD_SEQ8080_BYTESWAP_EN
    for (int i = 0; i < 15; i++) begin
      check("pin_byte", exp_q[i][7:0], lit_bytes[i]);
      check("pin_func", exp_q[i][10:8], (i == 0 || i == 5 || i == 10) ? 3'd1 : 3'd3);
    end
`endif

    // Basic 2-pixel window.
    run_fill("basic", 16'd0, 16'd1, 16'd0, 16'd0, 2, -1, 0, 15);

    // Rejected window.
    e0 = errs; s0 = strobes;
    pulse_start(16'd5, 16'd4, 16'd0, 16'd0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("err_pulse", errs - e0, 1);
    check("err_no_strobe", strobes - s0, 0);
    check("err_busy_back", busy, 0);
    check("err_queue_untouched", exp_q.size(), 0);

    // Stall before the second pixel.
    run_fill("stall", 16'd0, 16'd1, 16'd0, 16'd0, 2, 1, 20, 15);

    // Reset during the second argument byte.
    build_expected(16'd0, 16'd1, 16'd0, 16'd0, 2);
    s0 = strobes; d0 = dones;
    pulse_start(16'd0, 16'd1, 16'd0, 16'd0);
    t = 0;
    while ((strobes - s0) < 3 && t < 500) begin
      @(posedge CLK);
      t++;
    end
    check("abort_reached_arg2", strobes - s0, 3);
    #1 RST = 1'b1;
    @(posedge CLK);
    #1 check_reset_outputs("abort");
    @(negedge CLK);
    RST = 1'b0;
    exp_q.delete();
    check("abort_no_done", dones - d0, 0);
    run_fill("restart", 16'd0, 16'd1, 16'd0, 16'd0, 2, -1, 0, 15);

    // start pulsed mid-fill is ignored.
    build_expected(16'd0, 16'd1, 16'd0, 16'd0, 2);
    s0 = strobes; d0 = dones;
    pulse_start(16'd0, 16'd1, 16'd0, 16'd0);
    repeat (8) @(negedge CLK);
    x0 = 16'd7; x1 = 16'd9; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    feed_pixels(2, -1, 0);
    wait_done(d0);
    @(negedge CLK);
    check("restart_ignored_strobes", strobes - s0, 15);
    check("restart_ignored_queue", exp_q.size(), 0);
    check("restart_ignored_done", dones - d0, 1);

    // 2x2 window with non-zero high address bytes.
    pix_list[0] = 16'hA55A; pix_list[1] = 16'h0001;
    pix_list[2] = 16'hFFFF; pix_list[3] = 16'h8000;
    run_fill("win2x2", 16'h0100, 16'h0101, 16'h0203, 16'h0204, 4, -1, 0, 19);

    // Single pixel window.
    pix_list[0] = 16'h1234;
    build_expected(16'd3, 16'd3, 16'd7, 16'd7, 1);
`ifdef LCD_SEQ8080_BYTESWAP_EN
    want_first = 8'h34;
`else
    want_first = 8'h12;
`endif
    check("pin_1x1_first_pix", exp_q[11][7:0], want_first);
    run_fill("win1x1", 16'd3, 16'd3, 16'd7, 16'd7, 1, -1, 0, 13);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lcd_seq8080.md
LCD_SEQ8080 -- requirements
Module: lcd_seq8080

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high. Ports: CLK, RST.
REQ-002 CLK  input  1  rising-edge system clock.
REQ-003 RST  input  1  synchronous active-high reset.
REQ-004 start  input  1  one-cycle request to begin a window fill; sampled only in IDLE.
REQ-005 x0, x1, y0, y1  input  16 each  inclusive window corners; captured on accepted start.
REQ-006 pix_data  input  16  RGB565 pixel.
REQ-007 pix_valid / pix_ready  input / output  1  pixel handshake; transfer when both high on a CLK edge.
REQ-008 p_cmd  output  8  command byte to port8080 cmd.
REQ-009 p_data  output  8  data byte to port8080 datain.
REQ-010 p_func  output  3  port8080 function code: 1 = command write, 3 = data write; 2 (read) is never issued.
REQ-011 p_en  output  1  one-cycle issue strobe to port8080 EN.
REQ-012 p_busy  input  1  port8080 busy.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done / err  output  1  one-cycle pulses: fill complete / window rejected.

Function
REQ-015 States SHALL be IDLE, CHK, CMD, ARG, PIX_HI, PIX_LO, WAIT, DONE.
REQ-016 IDLE -> CHK on start; start while busy is ignored.
REQ-017 CHK: x1<x0 or y1<y0 -> err pulse and IDLE, with no p_en; otherwise the pixel count is (x1-x0+1)*(y1-y0+1), held in an unsigned 32-bit counter.
REQ-018 Byte order: 0x2A; x0[15:8], x0[7:0], x1[15:8], x1[7:0]; 0x2B; y0 hi, y0 lo, y1 hi, y1 lo; 0x2C; then each pixel as hi byte, lo byte.
REQ-019 Commands SHALL use p_func=1 with the byte on p_cmd; arguments and pixel bytes SHALL use p_func=3 with the byte on p_data.
REQ-020 Each byte is one issue: p_en high for exactly one cycle, p_cmd/p_data/p_func stable from that cycle until the next issue. After each issue the FSM enters WAIT.
REQ-021 WAIT SHALL ignore p_busy in the first cycle after p_en (guard cycle) and then leave when p_busy==0.
REQ-022 pix_ready SHALL be high only in PIX_HI while no issue is outstanding. The pixel is latched on handshake and the hi byte issued the same cycle. A pixel_valid low stalls indefinitely with no p_en.
REQ-023 After the lo byte's WAIT completes: decrement the count; if zero -> DONE (done pulse, 1 cycle) -> IDLE; else -> PIX_HI.
REQ-024 A single-pixel window (x0==x1, y0==y1) SHALL issue exactly 13 strobes.

Reset
REQ-025 On RST, at the next edge: state=IDLE; p_en, pix_ready, busy, done, err = 0; p_cmd, p_data = 0x00; p_func = 0; counter cleared.
REQ-026 RST mid-fill SHALL abort without completing the current byte or pulsing done; the next start begins a fresh sequence from 0x2A.

Configuration
REQ-027 Macro LCD_SEQ8080_BYTESWAP_EN: when defined, each pixel is issued lo byte then hi byte; when undefined, hi byte then lo byte. Command and argument order SHALL be unaffected.

Structure
REQ-028 Package lcd_seq_pkg SHALL hold the p_func codes (FUNC_CMD=1, FUNC_RD=2, FUNC_DAT=3), the opcodes (CASET=0x2A, PASET=0x2B, RAMWR=0x2C) and the state enumeration.
REQ-029 Single module; no sub-module is warranted. The argument byte index SHALL be a 3-bit counter within the module.

Verification
REQ-030 Window x=0..1, y=0..0; pixels 0xF800, 0x07E0; port model with 3-cycle busy -> bytes 2A,00,00,00,01,2B,00,00,00,00,2C,F8,00,07,E0 in that order, 15 p_en strobes, then one done pulse.
REQ-031 x0=5, x1=4 -> err pulse within 2 cycles of start; no p_en; busy returns to 0.
REQ-032 Same as REQ-030 with pix_valid held low for 20 cycles before the 2nd pixel -> no p_en during the stall; same final byte stream.
REQ-033 RST asserted during the 2nd argument byte -> all outputs at reset values the next cycle; a new start reproduces the sequence from 0x2A.
REQ-034 start pulsed during an active fill -> ignored; the byte stream is unchanged.
REQ-035 With LCD_SEQ8080_BYTESWAP_EN defined, pixel 0x1234 in a 1x1 window -> pixel bytes 34 then 12; total of 13 strobes.
